neural_packet_serializer: RTL

NEURAL_PACKET_SERIALIZER -- requirements
Module: neural_packet_serializer

---
 rtl/neural_packet_serializer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/neural_packet_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : neural_packet_serializer
//  Purpose  : Buffers framed packets in a small FIFO and serializes each one
//             MSW-first into WORD_WIDTH words on a valid/ready stream.
//  Options  : NEURAL_SERIALIZER_CKSUM_EN - append an XOR checksum word to
//             every packet (tx_last then marks the checksum word).
//  Revision : 1.0 - initial release
// ============================================================================
module neural_packet_serializer #(
    parameter int PACKET_WIDTH = 64,
    parameter int WORD_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    sensor_clk,
    input  logic                    sensor_rst_n,
    input  logic [PACKET_WIDTH-1:0] framed_packet,
    input  logic                    framed_valid,
    output logic [WORD_WIDTH-1:0]   tx_word,
    output logic                    tx_valid,
    output logic                    tx_last,
    input  logic                    tx_ready,
    output logic                    fifo_full,
    output logic                    overflow,
    output logic [15:0]             drop_count
);

    localparam int WPP   = PACKET_WIDTH / WORD_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = (WPP > 1) ? $clog2(WPP) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPP - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
`ifdef NEURAL_SERIALIZER_CKSUM_EN
        SEND  = 2'd1,
        CKSUM = 2'd2
`else
        SEND  = 2'd1
`endif
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [PACKET_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [PACKET_WIDTH-1:0] shreg;
    logic [IDX_W-1:0]        idx;
    logic                    fifo_empty;
    logic                    transfer;
    logic                    pop;
    logic                    shift;
    logic                    push;
    logic                    drop;
    logic [PACKET_WIDTH-1:0] head;

`ifdef NEURAL_SERIALIZER_CKSUM_EN
    logic [WORD_WIDTH-1:0]   cksum_reg;

    function automatic logic [WORD_WIDTH-1:0] word_xor(input logic [PACKET_WIDTH-1:0] p);
        logic [WORD_WIDTH-1:0] acc;
        acc = '0;
        for (int k = 0; k < WPP; k++) begin
            acc = acc ^ p[PACKET_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH];
        end
        return acc;
    endfunction
`endif

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign head       = mem[rd_ptr];
    assign tx_valid   = (state != IDLE);
    assign transfer   = tx_valid && tx_ready;
    // A packet arriving at a full FIFO still fits if a slot frees on the same edge.
    assign push       = framed_valid && (!fifo_full || pop);
    assign drop       = framed_valid && fifo_full && !pop;

`ifdef NEURAL_SERIALIZER_CKSUM_EN
    assign tx_last = (state == CKSUM);
`else
    assign tx_last = (state == SEND) && (idx == LAST_IDX);
`endif

    // Output word: top of the shift register, or the checksum in its own state.
    always_comb begin
        tx_word = '0;
        if (tx_valid) begin
            tx_word = shreg[PACKET_WIDTH-1 -: WORD_WIDTH];
        end
`ifdef NEURAL_SERIALIZER_CKSUM_EN
        if (state == CKSUM) begin
            tx_word = cksum_reg;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge sensor_clk or negedge sensor_rst_n) begin
        if (!sensor_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, FIFO pop and shift decisions; final transfer chains straight into the next packet.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                if (transfer) begin
                    if (idx == LAST_IDX) begin
`ifdef NEURAL_SERIALIZER_CKSUM_EN
                        next_state = CKSUM;
`else
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            next_state = IDLE;
                        end
`endif
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
`ifdef NEURAL_SERIALIZER_CKSUM_EN
            CKSUM: begin
                if (transfer) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = SEND;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // Shift register and word index: load on pop, advance one word per non-final transfer.
    always_ff @(posedge sensor_clk or negedge sensor_rst_n) begin
        if (!sensor_rst_n) begin
            shreg     <= '0;
            idx       <= '0;
`ifdef NEURAL_SERIALIZER_CKSUM_EN
            cksum_reg <= '0;
`endif
        end else if (pop) begin
            shreg     <= head;
            idx       <= '0;
`ifdef NEURAL_SERIALIZER_CKSUM_EN
            cksum_reg <= word_xor(head);
`endif
        end else if (shift) begin
            shreg     <= shreg << WORD_WIDTH;
            idx       <= idx + IDX_W'(1);
        end
    end

    // Packet storage; slot contents need no reset since occupancy gates every read.
    always_ff @(posedge sensor_clk) begin
        if (push) begin
            mem[wr_ptr] <= framed_packet;
        end
    end

    // FIFO pointers (wrap naturally at a power-of-2 depth) and occupancy.
    always_ff @(posedge sensor_clk or negedge sensor_rst_n) begin
        if (!sensor_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge sensor_clk or negedge sensor_rst_n) begin
        if (!sensor_rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire
